// File: rtl/alu_req_scheduler_pkg.sv
// Shared opcodes and FSM encoding for the ALU request scheduler.
package alu_req_scheduler_pkg;
    localparam logic [2:0] OP_PASSB = 3'b000;
    localparam logic [2:0] OP_NOTB  = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_XOR   = 3'b100;
    localparam logic [2:0] OP_ADD   = 3'b101;
    localparam logic [2:0] OP_INCB  = 3'b110;
    localparam logic [2:0] OP_NEGB  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;
endpackage

// File: rtl/alu_req_scheduler_if.sv
// Request/response handshake bundle between client blocks and the scheduler.
interface alu_req_scheduler_if #(
    parameter int N    = 8,
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_dataa;
    logic [NREQ*N-1:0] req_datab;
    logic [NREQ*3-1:0] req_selop;
    logic              resp_valid;
    logic              resp_ready;
    logic [IDW-1:0]    resp_id;
    logic [N-1:0]      resp_result;
    logic              resp_cout;

    modport master (
        output req_valid, req_dataa, req_datab, req_selop, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_result, resp_cout
    );
    modport slave (
        input  req_valid, req_dataa, req_datab, req_selop, resp_ready,
        output req_ready, resp_valid, resp_id, resp_result, resp_cout
    );
endinterface

// File: rtl/alu_req_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (int'(ptr) + k) % NREQ;
            if (!any && req[i]) begin
                any      = 1'b1;
                grant[i] = 1'b1;
                idx      = IDW'(i);
            end
        end
    end
endmodule

// File: rtl/alu_req_scheduler.sv
// Shares one combinational processing_unit among NREQ requesters; round-robin,
// one op in flight, operands registered into the ALU and results captured a cycle later.
module alu_req_scheduler
    import alu_req_scheduler_pkg::*;
#(
    parameter int N    = 8,
    parameter int NREQ = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_req_scheduler_if.slave   bus,
    output logic [N-1:0]         pu_dataa,
    output logic [N-1:0]         pu_datab,
    output logic [2:0]           pu_selop,
    input  logic [N-1:0]         pu_result,
    input  logic                 pu_cout,
    output logic                 busy,
    output logic [15:0]          done_count
);
    localparam int IDW = $clog2(NREQ);

    state_t          state, state_nxt;
    logic [IDW-1:0]  rr_ptr, arb_ptr, resp_nxt_ptr, grant_idx, grant_id;
    logic [NREQ-1:0] grant;
    logic            any_req, resp_hs, accept;

    assign resp_hs      = bus.resp_valid & bus.resp_ready;
    assign resp_nxt_ptr = (bus.resp_id == IDW'(NREQ - 1)) ? '0 : bus.resp_id + 1'b1;
    // When a response retires in RESP, the new grant already sees the advanced pointer.
    assign arb_ptr      = (state == ST_RESP) ? resp_nxt_ptr : rr_ptr;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req   (bus.req_valid),
        .ptr   (arb_ptr),
        .grant (grant),
        .idx   (grant_idx),
        .any   (any_req)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (any_req) state_nxt = ST_EXEC;
            ST_EXEC: state_nxt = ST_RESP;
            ST_RESP: if (resp_hs) state_nxt = any_req ? ST_EXEC : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        accept = 1'b0;
        case (state)
            ST_IDLE: accept = any_req;
            ST_RESP: accept = resp_hs & any_req;
            default: accept = 1'b0;
        endcase
        bus.req_ready = accept ? grant : '0;
        busy          = (state != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pu_dataa        <= '0;
            pu_datab        <= '0;
            pu_selop        <= '0;
            grant_id        <= '0;
            rr_ptr          <= '0;
            bus.resp_valid  <= 1'b0;
            bus.resp_id     <= '0;
            bus.resp_result <= '0;
            bus.resp_cout   <= 1'b0;
            done_count      <= '0;
        end else begin
            // ALU inputs only move on an accept edge, so the PU never sees glitches.
            if (accept) begin
                pu_dataa <= bus.req_dataa[grant_idx*N +: N];
                pu_datab <= bus.req_datab[grant_idx*N +: N];
                pu_selop <= bus.req_selop[grant_idx*3 +: 3];
                grant_id <= grant_idx;
            end
            if (state == ST_EXEC) begin
                bus.resp_result <= pu_result;
                bus.resp_cout   <= pu_cout;
                bus.resp_id     <= grant_id;
                bus.resp_valid  <= 1'b1;
            end else if (resp_hs) begin
                bus.resp_valid <= 1'b0;
                done_count     <= done_count + 16'd1;
                rr_ptr         <= resp_nxt_ptr;
            end
        end
    end
endmodule
